cdb_arbiter: RTL and testbench

Shares the common data bus (CDB) between functional-unit result producers and the reorder buffer and reservation stations that consume it. Each requester posts one completed result into a private one-entry holding register. Every cycle the arbiter grants up to `NUM_LANE` held results onto the CDB lanes in round-robin order. A misprediction flush from commit discards all held results.

---
 rtl/Purple_Jade_pkg.sv | 18 +
 rtl/cdb_rr_picker.sv | 49 ++++
 rtl/cdb_arbiter.sv | 97 +++++++++
 tb/tb_cdb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/Purple_Jade_pkg.sv
// rtl/Purple_Jade_pkg.sv - shared core types: CDB payload and CDB arbitration sizing
package Purple_Jade_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      data;
  } CDB_t;

  localparam int CDB_WIDTH = $bits(CDB_t);

  localparam int NUM_CDB_REQ  = 4;
  localparam int NUM_CDB_LANE = 2;

endpackage

// File: rtl/cdb_rr_picker.sv
// rtl/cdb_rr_picker.sv - rotating multi-grant priority encoder for CDB lanes
module cdb_rr_picker
  import Purple_Jade_pkg::*;
#(
  parameter int NUM_REQ  = NUM_CDB_REQ,
  parameter int NUM_LANE = NUM_CDB_LANE,
  parameter int IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]                hold_v_i,
  input  logic [IDXW-1:0]                   rr_ptr_i,
  output logic [NUM_REQ-1:0]                grant_o,
  output logic [NUM_LANE-1:0]               lane_vld_o,
  output logic [NUM_LANE-1:0][IDXW-1:0]     lane_idx_o,
  output logic [IDXW-1:0]                   last_idx_o
);

  localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NUM_REQ);

  always_comb begin
    int            cnt;
    logic [IDXW:0] sum;
    logic [IDXW-1:0] idx;
    grant_o    = '0;
    lane_vld_o = '0;
    lane_idx_o = '0;
    last_idx_o = '0;
    cnt        = 0;
    sum        = '0;
    idx        = '0;
    // Walk requesters starting at rr_ptr; the k-th hit fills lane k.
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_i} + (IDXW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx = sum[IDXW-1:0];
      if (hold_v_i[idx] && (cnt < NUM_LANE)) begin
        grant_o[idx] = 1'b1;
        for (int l = 0; l < NUM_LANE; l++) begin
          if (cnt == l) begin
            lane_vld_o[l] = 1'b1;
            lane_idx_o[l] = idx;
          end
        end
        last_idx_o = idx;
        cnt        = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-producer holding registers shared onto NUM_LANE CDB lanes round-robin
module cdb_arbiter
  import Purple_Jade_pkg::*;
#(
  parameter int NUM_REQ  = NUM_CDB_REQ,
  parameter int NUM_LANE = NUM_CDB_LANE
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  CDB_t [NUM_REQ-1:0]         req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic                       flush_i,
  output CDB_t [NUM_LANE-1:0]        cdb_o,
  output logic [$clog2(NUM_REQ):0]   occupancy_o
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OCCW = $clog2(NUM_REQ) + 1;

  logic [NUM_REQ-1:0]            hold_v_q, hold_v_d;
  logic [CDB_WIDTH-1:0]          hold_data_q [NUM_REQ];
  logic [IDXW-1:0]               rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]            pick_grant;
  logic [NUM_LANE-1:0]           lane_vld;
  logic [NUM_LANE-1:0][IDXW-1:0] lane_idx;
  logic [IDXW-1:0]               last_idx;
  logic [NUM_REQ-1:0]            granted;
  logic [NUM_REQ-1:0]            accept;

  cdb_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .NUM_LANE (NUM_LANE),
    .IDXW     (IDXW)
  ) u_picker (
    .hold_v_i   (hold_v_q),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (pick_grant),
    .lane_vld_o (lane_vld),
    .lane_idx_o (lane_idx),
    .last_idx_o (last_idx)
  );

  // Ready depends only on state and flush, never on req_valid_i.
  assign granted     = pick_grant & {NUM_REQ{~flush_i}};
  assign req_ready_o = {NUM_REQ{~flush_i}} & (~hold_v_q | granted);
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    hold_v_d = (hold_v_q & ~granted) | accept;
    rr_ptr_d = rr_ptr_q;
    if (|granted) begin
      if (last_idx == IDXW'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                                rr_ptr_d = last_idx + 1'b1;
    end
    if (flush_i) begin
      hold_v_d = '0;
      rr_ptr_d = '0;
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_LANE; l++) begin
      cdb_o[l] = '0;
      if (lane_vld[l] && !flush_i) begin
        cdb_o[l]       = CDB_t'(hold_data_q[lane_idx[l]]);
        cdb_o[l].valid = 1'b1;
      end
    end
  end

  always_comb begin
    occupancy_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      occupancy_o = occupancy_o + OCCW'(hold_v_q[r]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_v_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Payload is qualified by hold_v_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < NUM_REQ; r++) begin
      if (accept[r]) hold_data_q[r] <= req_data_i[r];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter with 4 requesters and 2 lanes
module tb_cdb_arbiter;
  import Purple_Jade_pkg::*;

  localparam int NR = 4;
  localparam int NL = 2;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [NR-1:0]     req_valid_i;
  CDB_t [NR-1:0]     req_data_i;
  logic [NR-1:0]     req_ready_o;
  logic              flush_i;
  CDB_t [NL-1:0]     cdb_o;
  logic [2:0]        occupancy_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] expq [NR][$];

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_LANE(NL)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .flush_i     (flush_i),
    .cdb_o       (cdb_o),
    .occupancy_o (occupancy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic CDB_t mk(input int r, input logic [31:0] d);
    CDB_t c;
    c       = '0;
    c.valid = 1'b1;
    c.tag   = 6'(r);
    c.data  = d;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int l, input int r, input logic [31:0] d);
    chk($sformatf("lane%0d_valid", l), cdb_o[l].valid, 1);
    chk($sformatf("lane%0d_tag", l), cdb_o[l].tag, r);
    chk($sformatf("lane%0d_data", l), cdb_o[l].data, d);
  endtask

  task automatic lane_zero(input int l);
    chk($sformatf("lane%0d_idle", l), cdb_o[l], 0);
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [31:0] base);
    req_valid_i = v;
    for (int r = 0; r < NR; r++) req_data_i[r] = mk(r, base + 32'(r));
  endtask

  function automatic int sb_count();
    int s;
    s = 0;
    for (int r = 0; r < NR; r++) s += expq[r].size();
    return s;
  endfunction

  // Scoreboard: pop on broadcast, push on handshake, drop everything on flush/reset.
  always @(negedge clk) begin
    int r;
    if (reset_i) begin
      for (int q = 0; q < NR; q++) expq[q].delete();
    end else if (flush_i) begin
      chk("flush_cdb", |cdb_o, 0);
      chk("flush_rdy", req_ready_o, 0);
      for (int q = 0; q < NR; q++) expq[q].delete();
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (cdb_o[l].valid) begin
          r = int'(cdb_o[l].tag);
          chk("sb_tag", r < NR, 1);
          if (r < NR) begin
            chk("sb_hit", expq[r].size() != 0, 1);
            if (expq[r].size() != 0) chk("sb_data", cdb_o[l].data, expq[r].pop_front());
          end
        end else begin
          chk("idle_zero", cdb_o[l], 0);
        end
      end
      for (int q = 0; q < NR; q++)
        if (req_valid_i[q] && req_ready_o[q]) expq[q].push_back(req_data_i[q].data);
    end
  end

  initial begin
    logic [NR-1:0] hs;
    reset_i     = 1'b1;
    flush_i     = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    #2;
    chk("rst_cdb", |cdb_o, 0);
    chk("rst_rdy", req_ready_o, 4'hF);
    chk("rst_occ", occupancy_o, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // All four requesters in one cycle
    drive(4'hF, 32'h10);
    #1 chk("all4_rdy", req_ready_o, 4'hF);
    tick(); drive(4'h0, 32'h0);
    #1 chk("all4_occ4", occupancy_o, 4);
    lane(0, 0, 32'h10); lane(1, 1, 32'h11);
    chk("all4_rdy_g01", req_ready_o, 4'b0011);
    tick(); #1;
    chk("all4_occ2", occupancy_o, 2);
    lane(0, 2, 32'h12); lane(1, 3, 32'h13);
    chk("all4_rdy_g23", req_ready_o, 4'hF);
    tick(); #1;
    chk("all4_occ0", occupancy_o, 0);
    lane_zero(0); lane_zero(1);

    // Streaming from requester 1
    tick(); req_valid_i = 4'b0010; req_data_i[1] = mk(1, 32'hA);
    #1 chk("strm_rdy_a", req_ready_o[1], 1);
    tick(); req_data_i[1] = mk(1, 32'hB);
    #1 chk("strm_rdy_b", req_ready_o[1], 1);
    lane(0, 1, 32'hA); lane_zero(1);
    tick(); req_data_i[1] = mk(1, 32'hC);
    #1 chk("strm_rdy_c", req_ready_o[1], 1);
    lane(0, 1, 32'hB);
    tick(); req_valid_i = '0;
    #1 lane(0, 1, 32'hC);
    chk("strm_occ1", occupancy_o, 1);
    tick(); #1 chk("strm_occ0", occupancy_o, 0);

    // Pointer wrap: rr_ptr is 2; a lone grant to req2 moves it to 3
    tick(); drive(4'b0100, 32'h20);
    tick(); drive(4'b1011, 32'h30);
    #1 lane(0, 2, 32'h22); lane_zero(1);
    chk("wrap_rdy", req_ready_o, 4'hF);
    tick(); drive(4'h0, 32'h0);
    #1 lane(0, 3, 32'h33); lane(1, 0, 32'h30);
    chk("wrap_occ3", occupancy_o, 3);
    tick(); #1 lane(0, 1, 32'h31); lane_zero(1);
    chk("wrap_occ1", occupancy_o, 1);
    tick(); #1;

    // Flush with a concurrent request on req2
    tick(); drive(4'b1011, 32'h40);
    tick(); flush_i = 1'b1; drive(4'b0100, 32'h50);
    #1 chk("fl_cdb", |cdb_o, 0);
    chk("fl_rdy", req_ready_o, 4'h0);
    chk("fl_occ3", occupancy_o, 3);
    tick(); flush_i = 1'b0; drive(4'hF, 32'h50);
    #1 chk("fl_occ0", occupancy_o, 0);
    chk("fl_rdy_after", req_ready_o, 4'hF);
    chk("fl_cdb_after", |cdb_o, 0);
    tick(); drive(4'h0, 32'h0);
    #1 lane(0, 0, 32'h50); lane(1, 1, 32'h51);
    chk("fl_occ4", occupancy_o, 4);
    tick(); #1 lane(0, 2, 32'h52); lane(1, 3, 32'h53);
    tick(); #1 chk("fl_drain", occupancy_o, 0);

    // Unfairness probe: 0 and 1 always busy, 3 once
    tick(); drive(4'b1011, 32'h60);
    tick(); #1 lane(0, 0, 32'h60); lane(1, 1, 32'h61);
    chk("fair_rdy", req_ready_o, 4'b0111);
    drive(4'b0011, 32'h70);
    tick(); drive(4'b0011, 32'h80);
    #1 lane(0, 3, 32'h63); lane(1, 0, 32'h70);
    tick(); drive(4'h0, 32'h0);
    repeat (4) tick();

    // Randomised traffic with valid held until handshake and sporadic flushes
    hs = '0;
    for (int i = 0; i < 400; i++) begin
      hs = req_valid_i & req_ready_o;
      tick();
      flush_i = ($urandom_range(0, 15) == 0);
      for (int r = 0; r < NR; r++) begin
        if (hs[r] || !req_valid_i[r]) begin
          req_valid_i[r] = ($urandom_range(0, 2) != 0);
          req_data_i[r]  = mk(r, $urandom);
        end
      end
      #1 chk("rand_occ", occupancy_o, sb_count());
    end
    tick(); flush_i = 1'b0; req_valid_i = '0;
    repeat (6) tick();
    chk("rand_drain_sb", sb_count(), 0);
    chk("rand_drain_occ", occupancy_o, 0);

    // Reset between edges while results are held
    drive(4'hF, 32'h90);
    tick(); drive(4'h0, 32'h0);
    #2 reset_i = 1'b1;
    #1 chk("mrst_cdb", |cdb_o, 0);
    chk("mrst_rdy", req_ready_o, 4'hF);
    chk("mrst_occ", occupancy_o, 0);
    @(posedge clk);
    #1 reset_i = 1'b0;
    #1 chk("mrst_occ_after", occupancy_o, 0);
    drive(4'b0001, 32'hA0);
    tick(); drive(4'h0, 32'h0);
    #1 lane(0, 0, 32'hA0); lane_zero(1);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
